adder_pipe_vr: RTL and testbench

- Parametrised, pipelined unsigned adder/subtractor with valid/ready handshake on both sides.
- Successor to the fixed 4-bit enable-gated registered adder.
- Generalises width and pipeline depth, adds subtract and saturate modes, overflow flag, and backpressure.
- Serves as the datapath block and as the reference model for adder benches.

---
 rtl/adder_pipe_vr.sv | 164 ++++++++++++++++
 tb/tb_adder_pipe_vr.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe_vr.sv
// adder_pipe_vr: parametrised, pipelined unsigned adder/subtractor with a
// valid/ready handshake on both sides.
//
// Each of the STAGES pipeline registers resolves one WIDTH/STAGES-bit ripple
// slice and forwards the carry. It also forwards the not-yet-added high
// slices of A and B', the completed low sum slices, and the mode bits of
// its beat. Subtraction is A + ~B + 1: B is inverted and carry-in is set at
// slice 0. The whole pipeline advances together whenever the output
// register is empty or is being drained.
//
// Parameters:
//   WIDTH   operand width in bits (must be divisible by STAGES)
//   STAGES  pipeline depth, 1..4; latency is STAGES cycles
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset; discards in-flight beats
//   in_valid   input beat present
//   in_ready   block accepts input this cycle (= !out_valid || out_ready)
//   in_a       operand A, unsigned
//   in_b       operand B, unsigned
//   in_sub     0 = A+B, 1 = A-B
//   in_sat     0 = wrap, 1 = saturate
//   out_valid  result present
//   out_ready  downstream accepts result
//   out_sum    WIDTH+1 result; MSB is carry (add) or borrow (sub) when wrapping
//   out_ovf    carry-out (add) or borrow (sub), regardless of in_sat
module adder_pipe_vr #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             out_ovf
);

    localparam int SL = WIDTH / STAGES;

    // Stage registers: index k holds a beat whose slices 0..k are resolved.
    logic [STAGES-1:0] s_v;
    logic [WIDTH-1:0]  s_a   [STAGES];
    logic [WIDTH-1:0]  s_b   [STAGES];
    logic [WIDTH-1:0]  s_sum [STAGES];
    logic              s_c   [STAGES];
    logic              s_sub [STAGES];
    logic              s_sat [STAGES];

    // Next-state values for every stage.
    logic [STAGES-1:0] n_v;
    logic [WIDTH-1:0]  n_a   [STAGES];
    logic [WIDTH-1:0]  n_b   [STAGES];
    logic [WIDTH-1:0]  n_sum [STAGES];
    logic              n_c   [STAGES];
    logic              n_sub [STAGES];
    logic              n_sat [STAGES];

    // Source of the stage currently being evaluated in the loop below.
    logic              src_v;
    logic [WIDTH-1:0]  src_a;
    logic [WIDTH-1:0]  src_b;
    logic [WIDTH-1:0]  src_sum;
    logic              src_c;
    logic              src_sub;
    logic              src_sat;
    logic [SL:0]       part;

    logic adv;
    logic last_ovf;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = s_v[STAGES-1];

    always_comb begin
        src_v   = 1'b0;
        src_a   = '0;
        src_b   = '0;
        src_sum = '0;
        src_c   = 1'b0;
        src_sub = 1'b0;
        src_sat = 1'b0;
        part    = '0;
        n_v     = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                src_v   = in_valid;
                src_a   = in_a;
                src_b   = in_sub ? ~in_b : in_b;
                src_sum = '0;
                src_c   = in_sub;
                src_sub = in_sub;
                src_sat = in_sat;
            end else begin
                src_v   = s_v[k-1];
                src_a   = s_a[k-1];
                src_b   = s_b[k-1];
                src_sum = s_sum[k-1];
                src_c   = s_c[k-1];
                src_sub = s_sub[k-1];
                src_sat = s_sat[k-1];
            end
            part = {1'b0, src_a[k*SL +: SL]} + {1'b0, src_b[k*SL +: SL]}
                 + {{SL{1'b0}}, src_c};
            n_v[k]   = src_v;
            n_a[k]   = src_a;
            n_b[k]   = src_b;
            n_sum[k] = src_sum;
            n_sum[k][k*SL +: SL] = part[SL-1:0];
            n_c[k]   = part[SL];
            n_sub[k] = src_sub;
            n_sat[k] = src_sat;
        end
    end

    // Data registers load only with a valid beat, so bubbles never disturb
    // the held output value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_v <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                s_a[k]   <= '0;
                s_b[k]   <= '0;
                s_sum[k] <= '0;
                s_c[k]   <= 1'b0;
                s_sub[k] <= 1'b0;
                s_sat[k] <= 1'b0;
            end
        end else if (adv) begin
            s_v <= n_v;
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (n_v[k]) begin
                    s_a[k]   <= n_a[k];
                    s_b[k]   <= n_b[k];
                    s_sum[k] <= n_sum[k];
                    s_c[k]   <= n_c[k];
                    s_sub[k] <= n_sub[k];
                    s_sat[k] <= n_sat[k];
                end
            end
        end
    end

    // Borrow is the inverted carry when subtracting.
    assign last_ovf = s_sub[STAGES-1] ? !s_c[STAGES-1] : s_c[STAGES-1];
    assign out_ovf  = last_ovf;

    always_comb begin
        if (s_sat[STAGES-1] && last_ovf) begin
            out_sum = s_sub[STAGES-1] ? '0 : {1'b0, {WIDTH{1'b1}}};
        end else begin
            out_sum = {last_ovf, s_sum[STAGES-1]};
        end
    end

endmodule

// File: tb/tb_adder_pipe_vr.sv
module tb_adder_pipe_vr;

    localparam int W = 16;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           in_sub;
    logic           in_sat;
    logic           out_valid;
    logic           out_ready;
    logic [W:0]     out_sum;
    logic           out_ovf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adder_pipe_vr #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_sat    (in_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    // Reference: plain arithmetic on the operands; returns {ovf, out_sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub, input logic sat);
        logic [W:0] full;
        logic       ovf;
        if (sub) begin
            full = {1'b0, a} - {1'b0, b};
            ovf  = (a < b);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            ovf  = full[W];
        end
        if (sat && ovf) full = sub ? '0 : {1'b0, {W{1'b1}}};
        return {ovf, full};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one beat into an idle pipeline and reports latency and result.
    task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sub, input logic sat,
                            output int lat, output logic [W:0] sum, output logic ovf);
        in_a = a; in_b = b; in_sub = sub; in_sat = sat;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        sum = out_sum;
        ovf = out_ovf;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_sub = 1'b0; in_sat = 1'b0;
        #2;
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_vec++;
        if (out_sum !== '0) begin n_err++; $display("FAIL reset_sum: got %h expected 0", out_sum); end
        n_vec++;
        if (out_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", out_ovf); end
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add_basic();
        int lat; logic [W:0] sum; logic ovf;
        send_one(16'h1234, 16'h0FED, 1'b0, 1'b0, lat, sum, ovf);
        n_vec++;
        if (lat !== S) begin n_err++; $display("FAIL add_latency: got %0d expected %0d", lat, S); end
        n_vec++;
        if (sum !== 17'h02221) begin n_err++; $display("FAIL add_sum: got %h expected 02221", sum); end
        n_vec++;
        if (ovf !== 1'b0) begin n_err++; $display("FAIL add_ovf: got %b expected 0", ovf); end
    endtask

    task automatic test_carry_ovf();
        int lat; logic [W:0] sum; logic ovf;
        send_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, sum, ovf);
        n_vec++;
        if ({ovf, sum} !== {1'b1, 17'h10000}) begin
            n_err++; $display("FAIL carry_wrap: got ovf=%b sum=%h expected ovf=1 sum=10000", ovf, sum);
        end
        send_one(16'hFFFF, 16'h0001, 1'b0, 1'b1, lat, sum, ovf);
        n_vec++;
        if ({ovf, sum} !== {1'b1, 17'h0FFFF}) begin
            n_err++; $display("FAIL carry_sat: got ovf=%b sum=%h expected ovf=1 sum=0ffff", ovf, sum);
        end
    endtask

    task automatic test_subtract();
        int lat; logic [W:0] sum; logic ovf;
        send_one(16'h0005, 16'h0007, 1'b1, 1'b0, lat, sum, ovf);
        n_vec++;
        if ({ovf, sum} !== {1'b1, 17'h1FFFE}) begin
            n_err++; $display("FAIL sub_wrap: got ovf=%b sum=%h expected ovf=1 sum=1fffe", ovf, sum);
        end
        send_one(16'h0005, 16'h0007, 1'b1, 1'b1, lat, sum, ovf);
        n_vec++;
        if ({ovf, sum} !== {1'b1, 17'h00000}) begin
            n_err++; $display("FAIL sub_sat: got ovf=%b sum=%h expected ovf=1 sum=00000", ovf, sum);
        end
        send_one(16'h8000, 16'h0001, 1'b1, 1'b0, lat, sum, ovf);
        n_vec++;
        if ({ovf, sum} !== {1'b0, 17'h07FFF}) begin
            n_err++; $display("FAIL sub_nob: got ovf=%b sum=%h expected ovf=0 sum=07fff", ovf, sum);
        end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int out_idx = 0;
        int stall = 0;
        int cyc = 0;
        logic acc;
        while (out_idx < 4 && cyc < 60) begin
            in_valid = (idx < 4);
            in_a = W'(idx + 1); in_b = W'(idx + 1); in_sub = 1'b0; in_sat = 1'b0;
            if (out_valid && stall < 3) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = 1'b1;
            end
            @(negedge clk);
            if (!out_ready) begin
                n_vec++;
                if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
                n_vec++;
                if (out_valid !== 1'b1 || out_sum !== 17'h00002) begin
                    n_err++; $display("FAIL bp_hold: got valid=%b sum=%h expected valid=1 sum=00002", out_valid, out_sum);
                end
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (out_sum !== 17'(2 * (out_idx + 1))) begin
                    n_err++; $display("FAIL bp_order: got %h expected %h", out_sum, 17'(2 * (out_idx + 1)));
                end
                out_idx++;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        n_vec++;
        if (out_idx != 4 || idx != 4) begin
            n_err++; $display("FAIL bp_count: got in=%0d out=%0d expected 4 4", idx, out_idx);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_dup: got valid=%b expected 0", out_valid); end
    endtask

    task automatic test_reset_midstream();
        int lat; logic [W:0] sum; logic ovf;
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 16'd10; in_b = 16'd20; in_sub = 1'b0; in_sat = 1'b0;
        tick();
        in_a = 16'd30; in_b = 16'd40;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
        n_vec++;
        if (out_sum !== '0 || out_ovf !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_data: got sum=%h ovf=%b expected 0 0", out_sum, out_ovf);
        end
        tick();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_ghost: got %b expected 0", out_valid); end
        send_one(16'h0003, 16'h0004, 1'b0, 1'b0, lat, sum, ovf);
        n_vec++;
        if (lat !== S || sum !== 17'h00007 || ovf !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_after: got lat=%0d sum=%h ovf=%b expected %0d 00007 0", lat, sum, ovf, S);
        end
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] exp_q[$];
        logic [W+1:0] e;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic acc;
        logic started = 1'b0;
        out_ready = 1'b1;
        while (got < 6 && cyc < 30) begin
            in_valid = (sent < 6);
            in_a = W'($urandom); in_b = W'($urandom);
            in_sub = sent[0]; in_sat = sent[1];
            @(negedge clk);
            if (out_valid) begin
                started = 1'b1;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                n_vec++;
                if ({out_ovf, out_sum} !== e) begin
                    n_err++; $display("FAIL b2b_data: got %h expected %h", {out_ovf, out_sum}, e);
                end
                got++;
            end else if (started) begin
                n_vec++;
                n_err++; $display("FAIL b2b_gap: got valid=0 expected 1");
            end
            acc = in_valid && in_ready;
            if (acc) exp_q.push_back(model(in_a, in_b, in_sub, in_sat));
            tick();
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        n_vec++;
        if (got != 6) begin n_err++; $display("FAIL b2b_count: got %0d expected 6", got); end
    endtask

    task automatic test_random();
        logic [W+1:0] exp_q[$];
        logic [W+1:0] e;
        logic [W+1:0] held;
        logic hold = 1'b0;
        logic acc = 1'b1;
        int n_in = 0;
        int n_out = 0;
        int cyc = 0;
        in_valid = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_a = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
                in_b = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
                in_sub = $urandom_range(0, 1) != 0;
                in_sat = $urandom_range(0, 1) != 0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (hold) begin
                n_vec++;
                if (out_valid !== 1'b1 || {out_ovf, out_sum} !== held) begin
                    n_err++; $display("FAIL rnd_hold: got valid=%b %h expected valid=1 %h", out_valid, {out_ovf, out_sum}, held);
                end
            end
            n_vec++;
            if (in_ready !== (!out_valid || out_ready)) begin
                n_err++; $display("FAIL rnd_in_ready: got %b expected %b", in_ready, !out_valid || out_ready);
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL rnd_extra: got %h expected no beat", {out_ovf, out_sum});
                end else begin
                    e = exp_q.pop_front();
                    if ({out_ovf, out_sum} !== e) begin
                        n_err++; $display("FAIL rnd_data: got %h expected %h", {out_ovf, out_sum}, e);
                    end
                end
                n_out++;
            end
            hold = out_valid && !out_ready;
            held = {out_ovf, out_sum};
            acc = in_valid && in_ready;
            if (acc) begin
                exp_q.push_back(model(in_a, in_b, in_sub, in_sat));
                n_in++;
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && cyc < 20) begin
            @(negedge clk);
            if (out_valid) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({out_ovf, out_sum} !== e) begin
                    n_err++; $display("FAIL rnd_drain: got %h expected %h", {out_ovf, out_sum}, e);
                end
                n_out++;
            end
            tick();
            cyc++;
        end
        n_vec++;
        if (n_in != n_out || exp_q.size() != 0) begin
            n_err++; $display("FAIL rnd_count: got out=%0d expected %0d", n_out, n_in);
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_carry_ovf();
        test_subtract();
        test_backpressure();
        test_reset_midstream();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
